flipflop_i_decoder: RTL and testbench
=====================================

Name: flipflop_i_decoder

Overview:
- Holds the 8-bit internal instruction code for the I-prefix (IX/IY) group and decodes it back into one-hot execution group strobes plus operand fields.
- Receives the code built by the eight bit-encoder ORs on P2_Set.
- Sequences each group through a fixed number of execution steps, then releases.
- Sits between the I-group encoders and the execution/datapath control.

Parameters:
- STEP_W, 3, width of step counter; must hold max step index 3.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- set_valid  in  1  P2_Set strobe; set_code valid this cycle
- set_code  in  8  encoded instruction code, bits 7..0 from encoders 7..0
- step_adv  in  1  datapath ready to advance one execution step
- abort  in  1  synchronous cancel of current instruction
- code_q  out  8  held instruction code
- busy  out  1  instruction held and executing
- step  out  STEP_W  current step index
- done  out  1  one-cycle pulse on final step completion
- set_reject  out  1  one-cycle pulse: set_valid refused (busy)
- illegal  out  1  one-cycle pulse: set_valid with unmapped code
- g_ld_idx_r, g_ld_idx_n, g_ld_dd_nn, g_ld_dd_mem, g_alu_n, g_alu_idx, g_incdec_idx, g_jp_cc  out  1 each  one-hot group, only while busy
- idx_y  out  1  0=IX, 1=IY
- fld  out  3  operand field (register/ALU op/cc/dd)
- hi_half  out  1  second-byte / second-half selector

Behaviour:
- Reset (async, rst=1): code_q=0x00, busy=0, step=0, done=0, set_reject=0, illegal=0, all g_* = 0.
- Decode map on code (x = don't care):
  - 0100_0xxx / 0101_0xxx except xxx=110 -> g_ld_idx_r; idx_y=code[4]; fld=code[2:0].
  - 1111_1x1x -> g_ld_idx_n; idx_y=code[2]; hi_half=code[0].
  - 0110_0xxx -> g_ld_dd_nn; fld={0,code[1:0]}; hi_half=code[2].
  - 0111_0xxx -> g_ld_dd_mem; fld and hi_half as for g_ld_dd_nn.
  - 1111_0xxx -> g_alu_n; fld=ALU op, bit order {code[2],code[1]... } = code[2:0] remapped to (ADD0, SUB1, AND2, OR3, ADC4, SBC5, XOR6, CP7) direct.
  - 110x_1xxx -> g_alu_idx; idx_y=code[4]; fld=code[2:0] with the same op mapping.
  - 1111_1x0x -> g_incdec_idx; idx_y=code[0]; hi_half=code[2] (0=INC, 1=DEC).
  - 010x_1xxx -> g_jp_cc; fld=cc=code[2:0]; hi_half=code[4].
  - All other codes, including 0x46 and 0x56, are unmapped.
- When not busy, fields idx_y/fld/hi_half = 0.
- Step counts (last step index): ld_idx_r 2, ld_idx_n 1, ld_dd_nn 1, ld_dd_mem 3, alu_n 0, alu_idx 2, incdec_idx 3, jp_cc 1.
- FSM IDLE/EXEC:
  - IDLE + set_valid + mapped: code_q<=set_code, busy<=1, step<=0 (next cycle).
  - IDLE + set_valid + unmapped: illegal=1 next cycle; code_q unchanged; stay IDLE.
  - EXEC + step_adv, step<last: step<=step+1.
  - EXEC + step_adv, step==last: done=1 next cycle; busy<=0, step<=0, code_q<=0x00.
  - Simultaneous final step_adv and set_valid: done pulses AND the new code loads (mapped) or illegal pulses (unmapped); no idle bubble.
  - EXEC + set_valid, not final step: set_reject=1 next cycle; held code unaffected.
  - abort (any state): busy<=0, step<=0, code_q<=0x00, no done; abort wins over step_adv and set_valid in the same cycle.
- g_* outputs are combinational from code_q gated by busy; exactly one high while busy.
- step never exceeds last; step_adv in IDLE is ignored.

Test Plan:
- Reset mid-EXEC (code 0x73, step=2) -> all outputs to reset values immediately, without waiting for clk.
- set_code=0x5B, set_valid, then 1 step_adv -> g_jp_cc=1, fld=3, hi_half=1; done pulses 1 cycle after the second step_adv; code_q=0x00 after.
- set_code=0xF0 with step_adv held high -> g_alu_n 1 cycle; done the cycle after; back-to-back set_code=0xCE at the done cycle -> loads, g_alu_idx, idx_y=0, fld=6.
- set_code=0x56 -> illegal pulses once, busy stays 0; set_code=0x00 -> illegal.
- Busy on 0xFD at step 1, set_valid with 0x40 -> set_reject pulse, code_q stays 0xFD, DEC IY completes at step 3.
- 0x72 at step 2: assert abort with step_adv and set_valid -> busy=0, no done, no reject, code_q=0x00.

Source files
------------

// File: rtl/flipflop_i_decoder_if.sv
// ============================================================================
// Module   : flipflop_i_decoder_if
// Purpose  : Handshake, code and decoded-strobe bundle between the I-group
//            encoders, the instruction flip-flop/decoder and execution control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface flipflop_i_decoder_if #(
  parameter int STEP_W = 3
);
  logic              set_valid;
  logic [7:0]        set_code;
  logic              step_adv;
  logic              abort;
  logic [7:0]        code_q;
  logic              busy;
  logic [STEP_W-1:0] step;
  logic              done;
  logic              set_reject;
  logic              illegal;
  logic              g_ld_idx_r;
  logic              g_ld_idx_n;
  logic              g_ld_dd_nn;
  logic              g_ld_dd_mem;
  logic              g_alu_n;
  logic              g_alu_idx;
  logic              g_incdec_idx;
  logic              g_jp_cc;
  logic              idx_y;
  logic [2:0]        fld;
  logic              hi_half;

  // Encoder / datapath side: drives the request and advance signals.
  modport master (
    output set_valid, set_code, step_adv, abort,
    input  code_q, busy, step, done, set_reject, illegal,
    input  g_ld_idx_r, g_ld_idx_n, g_ld_dd_nn, g_ld_dd_mem,
    input  g_alu_n, g_alu_idx, g_incdec_idx, g_jp_cc,
    input  idx_y, fld, hi_half
  );

  // Instruction flip-flop / decoder side.
  modport slave (
    input  set_valid, set_code, step_adv, abort,
    output code_q, busy, step, done, set_reject, illegal,
    output g_ld_idx_r, g_ld_idx_n, g_ld_dd_nn, g_ld_dd_mem,
    output g_alu_n, g_alu_idx, g_incdec_idx, g_jp_cc,
    output idx_y, fld, hi_half
  );
endinterface

`default_nettype wire

// File: rtl/flipflop_i_decoder.sv
// ============================================================================
// Module   : flipflop_i_decoder
// Purpose  : Holds the I-prefix (IX/IY) instruction code, decodes it into
//            one-hot execution group strobes plus operand fields, and steps
//            each group through its fixed number of execution steps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flipflop_i_decoder #(
  parameter int STEP_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  flipflop_i_decoder_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  // Group bit order: 0 ld_idx_r, 1 ld_idx_n, 2 ld_dd_nn, 3 ld_dd_mem,
  // 4 alu_n, 5 alu_idx, 6 incdec_idx, 7 jp_cc. All-zero means unmapped.
  function automatic logic [7:0] decode_grp(input logic [7:0] c);
    logic [7:0] g;
    g    = '0;
    g[0] = (c[7:5] == 3'b010) && !c[3] && (c[2:0] != 3'b110);
    g[1] = (c[7:3] == 5'b11111) && c[1];
    g[2] = (c[7:3] == 5'b01100);
    g[3] = (c[7:3] == 5'b01110);
    g[4] = (c[7:3] == 5'b11110);
    g[5] = (c[7:5] == 3'b110) && c[3];
    g[6] = (c[7:3] == 5'b11111) && !c[1];
    g[7] = (c[7:5] == 3'b010) && c[3];
    return g;
  endfunction

  // Index of the final execution step for a decoded group.
  function automatic logic [STEP_W-1:0] last_step(input logic [7:0] g);
    logic [1:0] n;
    n = 2'd0;
    if (g[0] | g[5]) n = 2'd2;
    if (g[1] | g[2] | g[7]) n = 2'd1;
    if (g[3] | g[6]) n = 2'd3;
    return STEP_W'(n);
  endfunction

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [7:0]        held_q, held_d;
  logic              done_q, done_d;
  logic              reject_q, reject_d;
  logic              illegal_q, illegal_d;

  logic [7:0] held_grp;
  logic [7:0] in_grp;
  logic       in_mapped;
  logic       busy;
  logic       final_step;
  logic       idx_y_w;
  logic [2:0] fld_w;
  logic       hi_half_w;

  assign held_grp   = decode_grp(held_q);
  assign in_grp     = decode_grp(bus.set_code);
  assign in_mapped  = |in_grp;
  assign busy       = (state_q == S_EXEC);
  assign final_step = busy && bus.step_adv && (step_q == last_step(held_grp));

  // State, step counter, held code and the one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      held_q    <= 8'h00;
      done_q    <= 1'b0;
      reject_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      held_q    <= held_d;
      done_q    <= done_d;
      reject_q  <= reject_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state: load/refuse new codes, advance steps, release or cancel.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    held_d    = held_q;
    done_d    = 1'b0;
    reject_d  = 1'b0;
    illegal_d = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
      step_d  = '0;
      held_d  = 8'h00;
    end else if (!busy || final_step) begin
      if (final_step) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        step_d  = '0;
        held_d  = 8'h00;
      end
      // A request arriving with the final step is accepted without a bubble.
      if (bus.set_valid) begin
        if (in_mapped) begin
          state_d = S_EXEC;
          step_d  = '0;
          held_d  = bus.set_code;
        end else begin
          illegal_d = 1'b1;
        end
      end
    end else begin
      if (bus.step_adv) step_d = step_q + STEP_W'(1);
      if (bus.set_valid) reject_d = 1'b1;
    end
  end

  // Operand fields, forced to zero whenever nothing is executing.
  always_comb begin
    idx_y_w   = 1'b0;
    fld_w     = 3'd0;
    hi_half_w = 1'b0;
    if (busy) begin
      if (held_grp[0] | held_grp[5]) begin
        idx_y_w = held_q[4];
        fld_w   = held_q[2:0];
      end
      if (held_grp[1]) begin
        idx_y_w   = held_q[2];
        hi_half_w = held_q[0];
      end
      if (held_grp[2] | held_grp[3]) begin
        fld_w     = {1'b0, held_q[1:0]};
        hi_half_w = held_q[2];
      end
      if (held_grp[4]) fld_w = held_q[2:0];
      if (held_grp[6]) begin
        idx_y_w   = held_q[0];
        hi_half_w = held_q[2];
      end
      if (held_grp[7]) begin
        fld_w     = held_q[2:0];
        hi_half_w = held_q[4];
      end
    end
  end

  assign bus.code_q       = held_q;
  assign bus.busy         = busy;
  assign bus.step         = step_q;
  assign bus.done         = done_q;
  assign bus.set_reject   = reject_q;
  assign bus.illegal      = illegal_q;
  assign bus.g_ld_idx_r   = busy & held_grp[0];
  assign bus.g_ld_idx_n   = busy & held_grp[1];
  assign bus.g_ld_dd_nn   = busy & held_grp[2];
  assign bus.g_ld_dd_mem  = busy & held_grp[3];
  assign bus.g_alu_n      = busy & held_grp[4];
  assign bus.g_alu_idx    = busy & held_grp[5];
  assign bus.g_incdec_idx = busy & held_grp[6];
  assign bus.g_jp_cc      = busy & held_grp[7];
  assign bus.idx_y        = idx_y_w;
  assign bus.fld          = fld_w;
  assign bus.hi_half      = hi_half_w;

endmodule

`default_nettype wire

// File: tb/tb_flipflop_i_decoder.sv
// ============================================================================
// Module   : tb_flipflop_i_decoder
// Purpose  : Directed scenarios plus randomized traffic for flipflop_i_decoder,
//            checked against a table-driven reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flipflop_i_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flipflop_i_decoder_if #(.STEP_W(3)) bus();

  flipflop_i_decoder #(.STEP_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Group table: code matches when (code & MASK) == VAL.
  logic [7:0] MASK [8] = '{8'hE8, 8'hFA, 8'hF8, 8'hF8, 8'hF8, 8'hE8, 8'hFA, 8'hE8};
  logic [7:0] VAL  [8] = '{8'h40, 8'hFA, 8'h60, 8'h70, 8'hF0, 8'hC8, 8'hF8, 8'h48};
  int         LAST [8] = '{2, 1, 1, 3, 0, 2, 3, 1};

  // Reference model state.
  bit         m_busy;
  logic [7:0] m_code;
  int         m_step;
  bit         m_done, m_rej, m_ill;

  function automatic int grp_of(input logic [7:0] c);
    for (int i = 0; i < 8; i++) begin
      if ((c & MASK[i]) == VAL[i]) begin
        if (i == 0 && c[2:0] == 3'b110) return -1;
        return i;
      end
    end
    return -1;
  endfunction

  function automatic logic [4:0] exp_fields(input bit busy, input logic [7:0] c);
    logic       idx, hi;
    logic [2:0] f;
    idx = 1'b0; hi = 1'b0; f = 3'd0;
    if (busy) begin
      case (grp_of(c))
        0: begin idx = c[4]; f = c[2:0]; end
        1: begin idx = c[2]; hi = c[0]; end
        2, 3: begin f = {1'b0, c[1:0]}; hi = c[2]; end
        4: f = c[2:0];
        5: begin idx = c[4]; f = c[2:0]; end
        6: begin idx = c[0]; hi = c[2]; end
        7: begin f = c[2:0]; hi = c[4]; end
        default: ;
      endcase
    end
    return {idx, f, hi};
  endfunction

  function automatic logic [7:0] exp_grp();
    logic [7:0] v;
    v = 8'h00;
    if (m_busy) v[grp_of(m_code)] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] dut_grp();
    return {bus.g_jp_cc, bus.g_incdec_idx, bus.g_alu_idx, bus.g_alu_n,
            bus.g_ld_dd_mem, bus.g_ld_dd_nn, bus.g_ld_idx_n, bus.g_ld_idx_r};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_code = 8'h00; m_step = 0; m_done = 0; m_rej = 0; m_ill = 0;
  endtask

  task automatic model_update(input bit sv, input logic [7:0] sc, input bit sa, input bit ab);
    bit accept;
    m_done = 0; m_rej = 0; m_ill = 0;
    accept = 0;
    if (ab) begin
      m_busy = 0; m_code = 8'h00; m_step = 0;
    end else if (!m_busy) begin
      accept = sv;
    end else if (sa && m_step == LAST[grp_of(m_code)]) begin
      m_done = 1; m_busy = 0; m_code = 8'h00; m_step = 0;
      accept = sv;
    end else begin
      if (sa) m_step = m_step + 1;
      if (sv) m_rej = 1;
    end
    if (accept) begin
      if (grp_of(sc) >= 0) begin
        m_busy = 1; m_code = sc; m_step = 0;
      end else begin
        m_ill = 1;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, and land just past the edge.
  task automatic tick(input bit sv, input logic [7:0] sc, input bit sa, input bit ab);
    bus.set_valid = sv;
    bus.set_code  = sc;
    bus.step_adv  = sa;
    bus.abort     = ab;
    model_update(sv, sc, sa, ab);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.set_valid = 0; bus.set_code = 8'h00; bus.step_adv = 0; bus.abort = 0;
    model_reset();
    #2;
    checks++;
    if (bus.code_q !== 8'h00 || bus.busy !== 1'b0 || bus.step !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: code_q=%h busy=%b step=%0d, want 00/0/0", bus.code_q, bus.busy, bus.step);
    end
    checks++;
    if (bus.done !== 1'b0 || bus.set_reject !== 1'b0 || bus.illegal !== 1'b0 || dut_grp() !== 8'h00) begin
      errors++;
      $display("FAIL reset_pulses: done=%b rej=%b ill=%b grp=%h, want all 0", bus.done, bus.set_reject, bus.illegal, dut_grp());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_jp_cc();
    tick(1, 8'h5B, 0, 0);
    checks++;
    if (dut_grp() !== 8'h80 || bus.fld !== 3'd3 || bus.hi_half !== 1'b1 || bus.code_q !== 8'h5B) begin
      errors++;
      $display("FAIL jp_load: grp=%h fld=%0d hi=%b code=%h, want 80/3/1/5B", dut_grp(), bus.fld, bus.hi_half, bus.code_q);
    end
    tick(0, 8'h00, 1, 0);
    checks++;
    if (bus.step !== 3'd1 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL jp_step1: step=%0d done=%b busy=%b, want 1/0/1", bus.step, bus.done, bus.busy);
    end
    tick(0, 8'h00, 1, 0);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.code_q !== 8'h00 || bus.fld !== 3'd0) begin
      errors++;
      $display("FAIL jp_done: done=%b busy=%b code=%h fld=%0d, want 1/0/00/0", bus.done, bus.busy, bus.code_q, bus.fld);
    end
    tick(0, 8'h00, 0, 0);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL jp_done_pulse: done=%b, want 0", bus.done);
    end
  endtask

  task automatic test_back_to_back();
    tick(1, 8'hF0, 1, 0);
    checks++;
    if (dut_grp() !== 8'h10 || bus.step !== 3'd0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL alu_n_load: grp=%h step=%0d done=%b, want 10/0/0", dut_grp(), bus.step, bus.done);
    end
    tick(1, 8'hCE, 1, 0);
    checks++;
    if (bus.done !== 1'b1 || dut_grp() !== 8'h20 || bus.idx_y !== 1'b0 || bus.fld !== 3'd6 || bus.code_q !== 8'hCE) begin
      errors++;
      $display("FAIL b2b_load: done=%b grp=%h idx=%b fld=%0d code=%h, want 1/20/0/6/CE",
               bus.done, dut_grp(), bus.idx_y, bus.fld, bus.code_q);
    end
    tick(0, 8'h00, 1, 0);
    tick(0, 8'h00, 1, 0);
    checks++;
    if (bus.step !== 3'd2 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL alu_idx_step2: step=%0d done=%b, want 2/0", bus.step, bus.done);
    end
    tick(0, 8'h00, 1, 0);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL alu_idx_done: done=%b busy=%b, want 1/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_illegal();
    tick(1, 8'h56, 0, 0);
    checks++;
    if (bus.illegal !== 1'b1 || bus.busy !== 1'b0 || bus.code_q !== 8'h00) begin
      errors++;
      $display("FAIL illegal_56: ill=%b busy=%b code=%h, want 1/0/00", bus.illegal, bus.busy, bus.code_q);
    end
    tick(0, 8'h00, 0, 0);
    checks++;
    if (bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse: ill=%b, want 0", bus.illegal);
    end
    tick(1, 8'h00, 0, 0);
    checks++;
    if (bus.illegal !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_00: ill=%b busy=%b, want 1/0", bus.illegal, bus.busy);
    end
    tick(1, 8'h46, 1, 0);
    checks++;
    if (bus.illegal !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_46: ill=%b busy=%b, want 1/0", bus.illegal, bus.busy);
    end
  endtask

  task automatic test_reject();
    tick(1, 8'hFD, 0, 0);
    checks++;
    if (dut_grp() !== 8'h40 || bus.idx_y !== 1'b1 || bus.hi_half !== 1'b1) begin
      errors++;
      $display("FAIL dec_iy_load: grp=%h idx=%b hi=%b, want 40/1/1", dut_grp(), bus.idx_y, bus.hi_half);
    end
    tick(0, 8'h00, 1, 0);
    tick(1, 8'h40, 0, 0);
    checks++;
    if (bus.set_reject !== 1'b1 || bus.code_q !== 8'hFD || bus.step !== 3'd1) begin
      errors++;
      $display("FAIL reject: rej=%b code=%h step=%0d, want 1/FD/1", bus.set_reject, bus.code_q, bus.step);
    end
    tick(0, 8'h00, 1, 0);
    tick(0, 8'h00, 1, 0);
    checks++;
    if (bus.step !== 3'd3 || bus.set_reject !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL dec_iy_step3: step=%0d rej=%b done=%b, want 3/0/0", bus.step, bus.set_reject, bus.done);
    end
    tick(0, 8'h00, 1, 0);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL dec_iy_done: done=%b busy=%b, want 1/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_abort();
    tick(1, 8'h72, 0, 0);
    tick(0, 8'h00, 1, 0);
    tick(0, 8'h00, 1, 0);
    tick(1, 8'h40, 1, 1);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.set_reject !== 1'b0 ||
        bus.illegal !== 1'b0 || bus.code_q !== 8'h00 || bus.step !== 3'd0) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b rej=%b ill=%b code=%h step=%0d, want 0/0/0/0/00/0",
               bus.busy, bus.done, bus.set_reject, bus.illegal, bus.code_q, bus.step);
    end
    tick(1, 8'h5B, 0, 1);
    checks++;
    if (bus.busy !== 1'b0 || bus.code_q !== 8'h00) begin
      errors++;
      $display("FAIL abort_idle: busy=%b code=%h, want 0/00", bus.busy, bus.code_q);
    end
  endtask

  task automatic test_reset_mid_exec();
    tick(1, 8'h73, 0, 0);
    tick(0, 8'h00, 1, 0);
    tick(0, 8'h00, 1, 0);
    checks++;
    if (bus.step !== 3'd2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: step=%0d busy=%b, want 2/1", bus.step, bus.busy);
    end
    bus.step_adv = 0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.step !== 3'd0 || bus.code_q !== 8'h00 || dut_grp() !== 8'h00 || bus.fld !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b step=%0d code=%h grp=%h fld=%0d, want 0/0/00/00/0",
               bus.busy, bus.step, bus.code_q, dut_grp(), bus.fld);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] pool [8] = '{8'h5B, 8'hF0, 8'hCE, 8'hFD, 8'h72, 8'h41, 8'hFA, 8'h63};
    logic [7:0] code;
    logic [4:0] fe;
    for (int n = 0; n < 400; n++) begin
      code = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : 8'($urandom);
      tick($urandom_range(0, 2) == 0, code, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      fe = exp_fields(m_busy, m_code);
      checks++;
      if (bus.busy !== m_busy || bus.code_q !== m_code || bus.step !== 3'(m_step)) begin
        errors++;
        $display("FAIL rand_state[%0d]: busy=%b code=%h step=%0d, want %b/%h/%0d",
                 n, bus.busy, bus.code_q, bus.step, m_busy, m_code, m_step);
      end
      checks++;
      if (bus.done !== m_done || bus.set_reject !== m_rej || bus.illegal !== m_ill) begin
        errors++;
        $display("FAIL rand_pulses[%0d]: done=%b rej=%b ill=%b, want %b/%b/%b",
                 n, bus.done, bus.set_reject, bus.illegal, m_done, m_rej, m_ill);
      end
      checks++;
      if (dut_grp() !== exp_grp() || {bus.idx_y, bus.fld, bus.hi_half} !== fe) begin
        errors++;
        $display("FAIL rand_decode[%0d]: grp=%h fields=%b, want %h/%b",
                 n, dut_grp(), {bus.idx_y, bus.fld, bus.hi_half}, exp_grp(), fe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jp_cc();
    test_back_to_back();
    test_illegal();
    test_reject();
    test_abort();
    test_reset_mid_exec();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
